bit_reverse_arbiter: RTL
========================

Name: bit_reverse_arbiter

Overview:
Shares a single combinational 8-bit bit-reversal unit between two requesters.
- Round-robin arbitration picks a requester.
- The accepted byte is registered and driven into the shared unit; the reversed result is captured.
- The result is presented on a valid/ready output port tagged with the source requester.
- The block also keeps a saturating count of completed transactions.

Parameters:
DATA_W, 8, width of request/result data and of the reversal unit interface
CNT_W, 16, width of the completed-transaction counter

Ports:
clk  input  1  single system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has data
req0_data  input  DATA_W  requester 0 byte to reverse
req0_ready  output  1  requester 0 transfer accepted this cycle
req1_valid  input  1  requester 1 has data
req1_data  input  DATA_W  requester 1 byte to reverse
req1_ready  output  1  requester 1 transfer accepted this cycle
rev_in  output  DATA_W  registered operand driven to shared reversal unit
rev_out  input  DATA_W  combinational result from reversal unit (rev_out[i] = rev_in[DATA_W-1-i])
out_valid  output  1  result available
out_data  output  DATA_W  reversed result
out_src  output  1  requester index that produced out_data
out_ready  input  1  downstream accepts result
done_count  output  CNT_W  completed output handshakes, saturating
busy  output  1  high whenever state != IDLE

Behaviour:
Reset:
- rst_n low acts immediately, independent of clk.
- state=IDLE, priority pointer=0, rev_in=0, out_valid=0, out_data=0, out_src=0, done_count=0.
- req*_ready=0 while reset is asserted.
- Reset mid-transaction discards the in-flight operand/result; no output is produced for it.

FSM states: IDLE, CAPTURE, RESULT.
- IDLE:
  - Grant is combinational from the valids and the pointer. One valid: grant it. Both valid: grant the pointer value. None: no grant.
  - reqX_ready = (state==IDLE) && grant==X. At most one ready is high per cycle.
  - Transfer on reqX_valid && reqX_ready at a rising edge. At that edge: rev_in<=reqX_data, out_src<=X, state<=CAPTURE.
- CAPTURE (exactly one cycle): out_data<=rev_out, out_valid<=1, state<=RESULT.
- RESULT:
  - out_valid, out_data and out_src are held stable until out_valid && out_ready at a rising edge.
  - On that edge: out_valid<=0; done_count increments, saturating at 2^CNT_W-1; pointer<=~out_src; state<=IDLE.
- Outside IDLE both ready outputs are 0; requesters simply wait.

Timing:
- Accept at edge E0; out_valid is high from edge E1.
- Minimum spacing between accepts is 3 cycles (accept, capture, output handshake with out_ready=1).
- rev_in holds the last operand when not reloaded (no toggling while idle).
- Requester valid may deassert without a transfer; no state change results.

Fairness: after serving X the pointer favours the other requester, so under continuous contention grants strictly alternate. The pointer is unchanged if no transfer completes.

Widths: out_data is a straight capture of rev_out; no arithmetic besides the counter. The counter never wraps.

Test Plan:
- Reset, then req0_valid with 0x01, out_ready=1 -> req0_ready high same cycle; out_valid from E1 with out_data=0x80, out_src=0; done_count=1 after handshake; busy high for 2 cycles.
- Both valid from reset, req0=0x0F, req1=0x33, held -> results 0xF0 (src 0), then 0xCC (src 1), then 0xF0 (src 0), alternating; each accept 3 cycles apart.
- Only req1 valid continuously with 0xA5, out_ready=1 -> 0xA5 out every 3 cycles, src=1, req0_ready never high.
- In RESULT with out_data=0x80, hold out_ready low 5 cycles -> out_valid/out_data/out_src stable, both ready outputs 0, done_count unchanged; completes on first out_ready high.
- Assert rst_n low asynchronously (mid-cycle) while in CAPTURE -> out_valid=0, out_data=0, rev_in=0, done_count=0 immediately; no result for the dropped operand; next request after release is served normally.
- With CNT_W=2, run 5 transactions -> done_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/bit_reverse_arbiter.sv
// Two-requester round-robin front end for a shared combinational bit-reversal unit.
// The operand is registered onto rev_in, the result is captured and offered on a valid/ready port.
module bit_reverse_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [DATA_W-1:0] rev_in,
    input  logic [DATA_W-1:0] rev_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  done_count,
    output logic              busy
);

    // state   | meaning
    // IDLE    | arbitrating, ready asserted toward the granted requester
    // CAPTURE | operand on rev_in, latch rev_out next edge
    // RESULT  | result offered downstream until out_ready
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        RESULT  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   ptr;
    logic   grant_valid;
    logic   grant_idx;
    logic   xfer;
    logic   done;

    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_idx   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_idx = ptr;
        end else if (req1_valid) begin
            grant_idx = 1'b1;
        end
    end

    // Readies are gated by rst_n so nothing is offered while reset is held.
    assign req0_ready = rst_n && (state == IDLE) && grant_valid && !grant_idx;
    assign req1_ready = rst_n && (state == IDLE) && grant_valid && grant_idx;

    assign xfer = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign done = (state == RESULT) && out_valid && out_ready;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESULT;
            RESULT:  if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= 1'b0;
            rev_in     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= 1'b0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        rev_in  <= grant_idx ? req1_data : req0_data;
                        out_src <= grant_idx;
                    end
                end
                CAPTURE: begin
                    out_data  <= rev_out;
                    out_valid <= 1'b1;
                end
                RESULT: begin
                    if (done) begin
                        out_valid <= 1'b0;
                        ptr       <= ~out_src;
                        if (done_count != {CNT_W{1'b1}}) begin
                            done_count <= done_count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
